lfsr_period_monitor: RTL and testbench
======================================

# lfsr_period_monitor

- Downstream consumer of the `lfsr` stage. It samples `lfsr_data` every clock after a start request and measures the sequence period.
- Period is the number of clocks until the captured starting value recurs.
- Flags all-zero lockup and runaway sequences.
- Used in bring-up and self-test to confirm the LFSR produces a maximal-length sequence after `load_seed`.

## Interface
Parameters:
- N, 4, LFSR width; must match the upstream `lfsr` instance.

Ports:
- clk  in  1  single system clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low; 0 clears all state immediately.
- start  in  1  begin a measurement; sampled in IDLE or DONE, ignored in COUNT.
- lfsr_data  in  N  upstream LFSR output, sampled every rising edge.
- busy  out  1  high while in COUNT.
- done  out  1  level; high in DONE until the next accepted start or reset.
- period  out  N+1  measured period; valid when done=1 and both error flags are 0.
- err_lockup  out  1  `lfsr_data` was all-zero at capture or during COUNT.
- err_timeout  out  1  starting value not seen again within 2^N clocks.

## Operation
- States: IDLE, COUNT, DONE.
- Reset: state=IDLE; busy=0, done=0, period=0, err_lockup=0, err_timeout=0; ref and count registers=0.
- IDLE or DONE, start=1:
  - Clear done, period and both error flags.
  - ref<=lfsr_data; count<=1.
  - If lfsr_data==0: set err_lockup, done=1, state DONE (no COUNT cycles).
  - Otherwise: state COUNT.
- COUNT, each edge, checks in priority order:
  1. lfsr_data==0: err_lockup=1, period=0, done=1, state DONE.
  2. lfsr_data==ref: period<=count, done=1, state DONE.
  3. count==2^N: err_timeout=1, period=0, done=1, state DONE.
  4. Otherwise: count<=count+1.
- Counter and period are N+1 bits wide. count never exceeds 2^N, so there is no wrap-around.
- start asserted during COUNT has no effect.
- DONE: all outputs held; a new start is accepted directly from DONE (no return to IDLE needed).
- Reset asserted mid-COUNT: immediate return to the reset values, no partial result kept.
- Valid maximal-length result: period = 2^N−1.

## Timing
- All outputs are registered; no combinational path from inputs to outputs.
- Start accepted at edge E0; the first comparison is at edge E1.
- A match at edge Ek makes done=1 and period=k visible after Ek. Latency from start acceptance equals the period.
- Zero at capture: done and err_lockup are visible after E0.
- Timeout: flagged after edge E(2^N) when no match has occurred (E16 for N=4).
- busy rises after E0 and falls on the same edge that done rises; busy and done are never both high.

## Structure
- Shared package `lfsr_pkg` holds:
  - typedef enum `mon_state_t` {IDLE, COUNT, DONE};
  - localparam `LFSR_N_DEFAULT` = 4;
  - a function returning 2^N for the timeout limit.
- Single module, no sub-modules: one FSM always_ff block plus next-state/compare logic.

## Test plan
- Real `lfsr` (N=4, seed 4'b1111) drives lfsr_data; start one clock after load_seed drops -> done after 15 edges, period=15, both error flags 0.
- lfsr_data held at 4'b0000 at start -> err_lockup=1, done=1 after E0, period=0, busy never rises.
- lfsr_data held constant at 4'b0101 -> period=1, done after E1.
- Bench drives a nonzero sequence that never repeats ref (ref=4'b1000, then cycle 1..7) -> err_timeout=1 after E16, period=0.
- Sequence 4'b1111, 4'b0111, 4'b0000 -> err_lockup=1 after E2; start pulses during COUNT change nothing.
- reset driven low mid-COUNT at E5 -> all outputs 0 immediately. After release, a new start gives a correct period=15.

Source files
------------

// File: rtl/lfsr_pkg.sv
// -----------------------------------------------------------------------------
// lfsr_pkg
//   Shared definitions for the LFSR stage and its period monitor.
//
//   Contents:
//     mon_state_t     - monitor FSM states (IDLE, COUNT, DONE)
//     LFSR_N_DEFAULT  - default LFSR width
//     timeout_limit() - 2^n, the largest period a width-n LFSR can produce
//                       plus one; used as the monitor's runaway limit
// -----------------------------------------------------------------------------
package lfsr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    COUNT = 2'd1,
    DONE  = 2'd2
  } mon_state_t;

  localparam int LFSR_N_DEFAULT = 4;

  // A maximal-length width-n LFSR repeats after 2^n-1 clocks, so if the
  // starting value has not come back by 2^n clocks it never will.
  function automatic int unsigned timeout_limit(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// lfsr_period_monitor
//   Measures the period of the sequence presented on lfsr_data. On an
//   accepted start the current value is captured as the reference; every
//   following clock the new sample is compared with it and the number of
//   clocks until the reference recurs is reported. All-zero samples (LFSR
//   lockup) and sequences that never return to the reference within 2^N
//   clocks are flagged instead of producing a period.
//
// Handshake: start is a level sampled on each rising edge. It is accepted
//   whenever the monitor is in IDLE or DONE (busy=0) and ignored in COUNT
//   (busy=1). Once accepted, busy stays high until the same edge that raises
//   done; done is then held with period and both error flags until the next
//   accepted start or reset. busy and done are never high together.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   asynchronous active-low reset
//   start        in   begin a measurement (IDLE/DONE only)
//   lfsr_data    in   [N-1:0] upstream LFSR output
//   busy         out  measurement in progress
//   done         out  result available (level)
//   period       out  [N:0] measured period; meaningful when done=1 and
//                     neither error flag is set
//   err_lockup   out  all-zero value seen at capture or while counting
//   err_timeout  out  reference not seen again within 2^N clocks
//   fsm_state    out  [1:0] current FSM state (mon_state_t encoding), for
//                     observation only
// -----------------------------------------------------------------------------
module lfsr_period_monitor
  import lfsr_pkg::*;
#(
  parameter int N = LFSR_N_DEFAULT
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] lfsr_data,
  output logic         busy,
  output logic         done,
  output logic [N:0]   period,
  output logic         err_lockup,
  output logic         err_timeout,
  output logic [1:0]   fsm_state
);

  localparam int       CW    = N + 1;
  localparam logic [N:0] LIMIT = CW'(timeout_limit(N));

  mon_state_t   state;
  logic [N-1:0] ref_q;
  logic [N:0]   count;

  // Compare terms for the current sample, evaluated in priority order by
  // the FSM below: lockup beats a match, a match beats the timeout.
  logic data_zero;
  logic data_match;
  logic count_at_limit;

  always_comb begin
    data_zero      = (lfsr_data == '0);
    data_match     = (lfsr_data == ref_q);
    count_at_limit = (count == LIMIT);
  end

  assign fsm_state = state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      period      <= '0;
      err_lockup  <= 1'b0;
      err_timeout <= 1'b0;
      ref_q       <= '0;
      count       <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            ref_q       <= lfsr_data;
            count       <= CW'(1);
            period      <= '0;
            err_timeout <= 1'b0;
            if (data_zero) begin
              // A zero seed can never leave zero; report it straight away
              // without spending any COUNT cycles.
              err_lockup <= 1'b1;
              done       <= 1'b1;
              busy       <= 1'b0;
              state      <= DONE;
            end else begin
              err_lockup <= 1'b0;
              done       <= 1'b0;
              busy       <= 1'b1;
              state      <= COUNT;
            end
          end
        end

        COUNT: begin
          if (data_zero) begin
            err_lockup <= 1'b1;
            period     <= '0;
            done       <= 1'b1;
            busy       <= 1'b0;
            state      <= DONE;
          end else if (data_match) begin
            // count holds the number of edges since capture, which is the
            // period when the reference reappears.
            period <= count;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= DONE;
          end else if (count_at_limit) begin
            err_timeout <= 1'b1;
            period      <= '0;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= DONE;
          end else begin
            // Stops at LIMIT via the branch above, so no wrap is possible.
            count <= count + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// -----------------------------------------------------------------------------
// tb_lfsr_period_monitor
//   Self-checking bench for lfsr_period_monitor (N=4). Each scenario task
//   fills a sample table, computes the expected outcome from a behavioural
//   scan of that table, drives it one sample per clock and checks busy/done
//   every cycle plus the final result.
// -----------------------------------------------------------------------------
module tb_lfsr_period_monitor;
  import lfsr_pkg::*;

  localparam int N     = 4;
  localparam int LIMIT = 16;          // 2^N
  localparam int RW    = N + 3;       // {lockup, timeout, period[N:0]}

  // clock / reset
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start;
  logic [N-1:0] lfsr_data;
  logic         busy;
  logic         done;
  logic [N:0]   period;
  logic         err_lockup;
  logic         err_timeout;
  logic [1:0]   fsm_state;

  lfsr_period_monitor #(.N(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .lfsr_data   (lfsr_data),
    .busy        (busy),
    .done        (done),
    .period      (period),
    .err_lockup  (err_lockup),
    .err_timeout (err_timeout),
    .fsm_state   (fsm_state)
  );

  int checks   = 0;
  int failures = 0;

  // sample table: stim[k] is presented before edge Ek
  logic [N-1:0] stim [0:63];
  logic [RW-1:0] exp_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // reference model
  // ---------------------------------------------------------------------------
  // Scan the table from the spec's rules: reference is stim[0]; the result
  // is decided at the first k in 1..2^N where the sample is zero, equals
  // the reference, or k reaches 2^N.
  function automatic void model(output int end_k, output logic [RW-1:0] res);
    logic [N-1:0] r;
    r     = stim[0];
    end_k = 0;
    res   = '0;
    if (r == 0) begin
      res = {1'b1, 1'b0, 5'd0};
      return;
    end
    for (int k = 1; k <= LIMIT; k++) begin
      if (stim[k] == 0) begin
        end_k = k; res = {1'b1, 1'b0, 5'd0}; return;
      end else if (stim[k] == r) begin
        end_k = k; res = {1'b0, 1'b0, 5'(k)}; return;
      end else if (k == LIMIT) begin
        end_k = k; res = {1'b0, 1'b1, 5'd0}; return;
      end
    end
  endfunction

  // x^4 + x^3 + 1 maximal-length Fibonacci LFSR, stands in for the upstream
  // lfsr stage.
  function automatic void fill_lfsr(input logic [N-1:0] seed);
    logic [N-1:0] s;
    s = seed;
    for (int i = 0; i < 64; i++) begin
      stim[i] = s;
      s = {s[2:0], s[3] ^ s[2]};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // driver + per-cycle checks for one measurement
  // ---------------------------------------------------------------------------
  task automatic measure(input string name, input bit poke);
    int            end_k;
    logic [RW-1:0] res;
    logic [RW-1:0] exp_res;
    logic [RW-1:0] got;
    model(end_k, res);
    exp_q.push_back(res);

    @(negedge clk);
    start     = 1'b1;
    lfsr_data = stim[0];
    @(posedge clk); #1;
    checks++;
    if (end_k == 0) begin
      if ({busy, done} !== 2'b01) begin
        failures++;
        $display("FAIL %s_e0: busy/done=%b expected 01", name, {busy, done});
      end
    end else if ({busy, done} !== 2'b10) begin
      failures++;
      $display("FAIL %s_e0: busy/done=%b expected 10", name, {busy, done});
    end

    for (int k = 1; k <= end_k; k++) begin
      @(negedge clk);
      lfsr_data = stim[k];
      start     = poke ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1;
      if (k < end_k) begin
        checks++;
        if ({busy, done} !== 2'b10) begin
          failures++;
          $display("FAIL %s_e%0d: busy/done=%b expected 10", name, k, {busy, done});
        end
      end
    end

    @(negedge clk);
    start   = 1'b0;
    exp_res = exp_q.pop_front();
    got     = {err_lockup, err_timeout, period};
    checks++;
    if ({busy, done} !== 2'b01) begin
      failures++;
      $display("FAIL %s_done: busy/done=%b expected 01 at E%0d", name, {busy, done}, end_k);
    end
    checks++;
    if (got !== exp_res) begin
      failures++;
      $display("FAIL %s_result: lock/to/period=%b/%b/%0d expected %b/%b/%0d",
               name, got[6], got[5], got[4:0], exp_res[6], exp_res[5], exp_res[4:0]);
    end

    // DONE holds everything while start stays low
    for (int i = 0; i < 2; i++) begin
      lfsr_data = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
      @(negedge clk);
    end
    checks++;
    if ({busy, done, err_lockup, err_timeout, period} !== {2'b01, exp_res}) begin
      failures++;
      $display("FAIL %s_hold: busy/done/lock/to/period=%b%b/%b/%b/%0d expected 01/%b/%b/%0d",
               name, busy, done, err_lockup, err_timeout, period,
               exp_res[6], exp_res[5], exp_res[4:0]);
    end
  endtask

  // ---------------------------------------------------------------------------
  // scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    reset     = 1'b0;
    start     = 1'b0;
    lfsr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, done, err_lockup, err_timeout, period} !== '0 || fsm_state !== IDLE) begin
      failures++;
      $display("FAIL reset: outputs=%b state=%0d expected all zero, IDLE",
               {busy, done, err_lockup, err_timeout, period}, fsm_state);
    end
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_maximal();
    fill_lfsr(4'b1111);
    measure("maximal", 1'b0);
  endtask

  task automatic test_zero_capture();
    for (int i = 0; i < 64; i++) stim[i] = 4'b0000;
    measure("zero_capture", 1'b0);
  endtask

  task automatic test_constant();
    for (int i = 0; i < 64; i++) stim[i] = 4'b0101;
    measure("constant", 1'b0);
  endtask

  task automatic test_timeout();
    stim[0] = 4'b1000;
    for (int i = 1; i < 64; i++) stim[i] = 4'(((i - 1) % 7) + 1);
    measure("timeout", 1'b0);
  endtask

  task automatic test_lockup_mid();
    stim[0] = 4'b1111;
    stim[1] = 4'b0111;
    stim[2] = 4'b0000;
    for (int i = 3; i < 64; i++) stim[i] = 4'($urandom_range(1, 15));
    measure("lockup_mid", 1'b1);
  endtask

  task automatic test_reset_mid();
    fill_lfsr(4'b1111);
    @(negedge clk);
    start     = 1'b1;
    lfsr_data = stim[0];
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      start     = 1'b0;
      lfsr_data = stim[k];
    end
    @(posedge clk);          // E5
    #2 reset = 1'b0;         // asynchronous, mid-cycle
    #1;
    checks++;
    if ({busy, done, err_lockup, err_timeout, period} !== '0 || fsm_state !== IDLE) begin
      failures++;
      $display("FAIL reset_mid: outputs=%b state=%0d expected all zero, IDLE",
               {busy, done, err_lockup, err_timeout, period}, fsm_state);
    end
    @(negedge clk);
    reset = 1'b1;
    fill_lfsr(4'b1111);
    measure("after_reset", 1'b0);
  endtask

  // Randomized back-to-back measurements started straight from DONE.
  task automatic test_back_to_back();
    logic [N-1:0] pat [0:15];
    int           len;
    for (int it = 0; it < 30; it++) begin
      case ($urandom_range(0, 2))
        0: fill_lfsr(4'($urandom_range(1, 15)));
        1: begin
          len = $urandom_range(1, 17);
          for (int j = 0; j < 16; j++) pat[j] = 4'($urandom_range(1, 15));
          for (int i = 0; i < 64; i++) stim[i] = pat[i % (len > 16 ? 16 : len)];
          if (len == 17) stim[0] = 4'($urandom_range(1, 15));
        end
        default: begin
          for (int i = 0; i < 64; i++)
            stim[i] = ($urandom_range(0, 9) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
        end
      endcase
      measure($sformatf("rand%0d", it), 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    test_reset();
    test_maximal();
    test_zero_capture();
    test_constant();
    test_timeout();
    test_lockup_mid();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
